wbs_pdm_scheduler: RTL and testbench

// Wishbone-configured controller for CHANNELS PDM channel modulators. Holds a

---
 rtl/wbs_pdm_scheduler.sv | 159 +++++++++++++++
 tb/tb_wbs_pdm_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbs_pdm_scheduler.sv
// Wishbone-configured round-robin level scheduler for a bank of PDM channel modulators.
// Latency: bus ack 1 cycle after request; a channel strobe appears 1 cycle after its visit is decided.
// Backpressure: none; ack gaps requests by one cycle, and a tick that arrives during a scan is dropped and flagged as overrun.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_cyc_i .. wb_ack_o     wishbone slave (word addressed, 32-bit data)
//   ch_stb                   one-hot load strobe, one bit per channel
//   ch_data                  shared level bus, valid with ch_stb, held between strobes
//   tick_o                   one-cycle pulse in the first cycle of each scan
module wbs_pdm_scheduler #(
  parameter int CHANNELS       = 4,
  parameter int BIT_RESOLUTION = 8,
  parameter int DIV_WIDTH      = 16,
  parameter int DIV_RESET      = 1000,
  parameter int ADDR_WIDTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  output logic                      wb_ack_o,
  output logic [CHANNELS-1:0]       ch_stb,
  output logic [BIT_RESOLUTION-1:0] ch_data,
  output logic                      tick_o
);

  localparam int IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDXW-1:0]       LAST_IDX  = IDXW'(CHANNELS - 1);
  localparam logic [ADDR_WIDTH-1:0] DIV_ADDR  = ADDR_WIDTH'(2 * CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] STEP_ADDR = ADDR_WIDTH'(2 * CHANNELS + 1);
  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = ADDR_WIDTH'(2 * CHANNELS + 2);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                    state_q, state_d;
  logic [IDXW-1:0]           idx_q;
  logic [BIT_RESOLUTION-1:0] target_q  [CHANNELS];
  logic [BIT_RESOLUTION-1:0] current_q [CHANNELS];
  logic [BIT_RESOLUTION-1:0] step_q;
  logic [DIV_WIDTH-1:0]      divider_q, presc_q;
  logic                      overrun_q;

  logic        bus_req, wr_en, rd_en, tick, busy, ovr_set;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign bus_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en   = bus_req & wb_we_i;
  assign rd_en   = bus_req & ~wb_we_i;
  assign tick    = (presc_q == divider_q);
  assign busy    = (state_q == SCAN);
  assign ovr_set = tick & busy;
  assign unused_bits = ^wb_dat_i;

  // Read data is captured at request time. A tick landing in the same cycle
  // as a status read is reported immediately so the event is never lost.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wb_adr_i == ADDR_WIDTH'(i))            rd_data = 32'(target_q[i]);
      if (wb_adr_i == ADDR_WIDTH'(CHANNELS + i)) rd_data = 32'(current_q[i]);
    end
    if (wb_adr_i == DIV_ADDR)  rd_data = 32'(divider_q);
    if (wb_adr_i == STEP_ADDR) rd_data = 32'(step_q);
    if (wb_adr_i == STAT_ADDR) rd_data = {30'd0, busy, overrun_q | ovr_set};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      step_q    <= '0;
      divider_q <= DIV_WIDTH'(DIV_RESET);
      overrun_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) target_q[i] <= '0;
    end else begin
      wb_ack_o <= bus_req;
      if (rd_en) wb_dat_o <= rd_data;
      if (wr_en) begin
        for (int i = 0; i < CHANNELS; i++)
          if (wb_adr_i == ADDR_WIDTH'(i)) target_q[i] <= wb_dat_i[BIT_RESOLUTION-1:0];
        if (wb_adr_i == DIV_ADDR)  divider_q <= wb_dat_i[DIV_WIDTH-1:0];
        if (wb_adr_i == STEP_ADDR) step_q    <= wb_dat_i[BIT_RESOLUTION-1:0];
      end
      // Set wins over clear-on-read.
      if (ovr_set)
        overrun_q <= 1'b1;
      else if (rd_en && wb_adr_i == STAT_ADDR)
        overrun_q <= 1'b0;
    end
  end

  // Prescaler: 0..divider, wrap produces the tick; a divider write restarts it.
  always_ff @(posedge clk) begin
    if (rst || (wr_en && wb_adr_i == DIV_ADDR) || tick)
      presc_q <= '0;
    else
      presc_q <= presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slew of the visited channel; the extra top bit carries the sign of the
  // difference so the step is applied toward the target without wrapping.
  logic [BIT_RESOLUTION-1:0] cur_lvl, tgt_lvl, new_lvl;
  logic [BIT_RESOLUTION:0]   diff, mag;

  always_comb begin
    cur_lvl = current_q[idx_q];
    tgt_lvl = target_q[idx_q];
    diff    = {1'b0, tgt_lvl} - {1'b0, cur_lvl};
    mag     = diff[BIT_RESOLUTION] ? -diff : diff;
    if (step_q == '0 || mag <= {1'b0, step_q})
      new_lvl = tgt_lvl;
    else if (diff[BIT_RESOLUTION])
      new_lvl = cur_lvl - step_q;
    else
      new_lvl = cur_lvl + step_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      tick_o  <= 1'b0;
      ch_stb  <= '0;
      ch_data <= '0;
      for (int i = 0; i < CHANNELS; i++) current_q[i] <= '0;
    end else begin
      tick_o <= tick & ~busy;
      ch_stb <= '0;
      if (!busy) begin
        idx_q <= '0;
      end else begin
        current_q[idx_q] <= new_lvl;
        ch_data          <= new_lvl;
        ch_stb[idx_q]    <= 1'b1;
        idx_q            <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wbs_pdm_scheduler.sv
module tb_wbs_pdm_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_adr = '0;
  logic [31:0] wb_dat_w = '0;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic [3:0]  ch_stb;
  logic [7:0]  ch_data;
  logic        tick_o;

  always #5 clk = ~clk;

  wbs_pdm_scheduler dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
    .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack),
    .ch_stb(ch_stb), .ch_data(ch_data), .tick_o(tick_o)
  );

  typedef struct {
    int         cyc;
    logic [3:0] stb;
    logic [7:0] dat;
  } stb_ev_t;

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  int      total = 0, bad = 0;
  int      cyc_cnt = 0;
  int      onehot_err = 0;
  int      fall_cyc = 0;
  stb_ev_t stb_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    stb_ev_t ev;
    if (ch_stb != 4'b0000) begin
      ev.cyc = cyc_cnt; ev.stb = ch_stb; ev.dat = ch_data;
      stb_q.push_back(ev);
    end
    if ($countones(ch_stb) > 1) onehot_err = onehot_err + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // All bus/wait tasks start and end 1 time unit after a rising edge.
  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    bit got = 1'b0;
    rdat = '0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = wdat;
    for (int n = 0; n < 4 && !got; n++) begin
      @(posedge clk); #1;
      if (wb_ack) begin got = 1'b1; rdat = wb_dat_r; end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (!got) timeout("wb_ack");
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic rd(input logic [3:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'd0, d);
  endtask

  task automatic wait_tick(input int limit, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < limit && !seen; n++) begin
      @(posedge clk); #1;
      if (tick_o) seen = 1'b1;
    end
    if (!seen) timeout("tick");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fall_cyc = cyc_cnt;
  endtask

  initial begin
    vec_t        vt [24];
    logic [31:0] d;
    logic [7:0]  ch0 [$];
    logic [7:0]  ch3 [$];
    logic [7:0]  exp_up [5];
    logic [7:0]  exp_dn [4];
    logic [3:0]  es;
    bit          seen;
    int          t0, t1;

    for (int i = 0; i < 16; i++) vt[i] = '{1'b0, 4'(i), 32'd0, (i == 8) ? 32'd1000 : 32'd0};
    vt[16] = '{1'b1, 4'd1,  32'h0000_01AB, 32'd0};
    vt[17] = '{1'b0, 4'd1,  32'd0,         32'h0000_00AB};
    vt[18] = '{1'b1, 4'd9,  32'hFFFF_FF3C, 32'd0};
    vt[19] = '{1'b0, 4'd9,  32'd0,         32'h0000_003C};
    vt[20] = '{1'b1, 4'd5,  32'h0000_0055, 32'd0};
    vt[21] = '{1'b0, 4'd5,  32'd0,         32'd0};
    vt[22] = '{1'b1, 4'd13, 32'h0000_0077, 32'd0};
    vt[23] = '{1'b0, 4'd13, 32'd0,         32'd0};
    exp_up = '{8'h10, 8'h20, 8'h30, 8'h35, 8'h35};
    exp_dn = '{8'h25, 8'h15, 8'h05, 8'h00};

    // Reset state, register map, first tick timing.
    do_reset();
    check("rst_ch_stb", 32'(ch_stb), 32'd0);
    check("rst_ch_data", 32'(ch_data), 32'd0);
    check("rst_tick", 32'(tick_o), 32'd0);
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_dat", wb_dat_r, 32'd0);
    stb_q.delete();
    for (int i = 0; i < 24; i++) begin
      wb_xfer(vt[i].we, vt[i].adr, vt[i].wdat, d);
      if (!vt[i].we) check($sformatf("regvec%0d", i), d, vt[i].exp);
    end
    wait_tick(1200, seen);
    if (seen) begin
      check("first_tick_delay", 32'(cyc_cnt - fall_cyc), 32'd1001);
      check("no_stb_before_tick", 32'(stb_q.size()), 32'd0);
    end

    // divider=9, step=0, target[2]=0xC8.
    do_reset();
    wr(4'd2, 32'hC8);
    wr(4'd9, 32'h0);
    wr(4'd8, 32'd9);
    stb_q.delete();
    wait_tick(30, seen);
    t0 = cyc_cnt;
    wait_tick(30, seen);
    t1 = cyc_cnt;
    check("tick_period", 32'(t1 - t0), 32'd10);
    check("scan_len", 32'(stb_q.size()), 32'd4);
    if (stb_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        es = 4'b0001 << k;
        check($sformatf("scan_cyc%0d", k), 32'(stb_q[k].cyc - t0), 32'(k + 1));
        check($sformatf("scan_stb%0d", k), {20'd0, stb_q[k].stb, stb_q[k].dat},
              {20'd0, es, (k == 2) ? 8'hC8 : 8'h00});
      end
    end
    wait_cycles(3);
    rd(4'd6, d);
    check("current2", d, 32'hC8);

    // Slewing with step 0x10, up then down.
    do_reset();
    wr(4'd0, 32'h35);
    wr(4'd9, 32'h10);
    stb_q.delete();
    wr(4'd8, 32'd9);
    wait_cycles(60);
    foreach (stb_q[k]) if (stb_q[k].stb == 4'b0001) ch0.push_back(stb_q[k].dat);
    check("slew_up_count_ge5", 32'(ch0.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < ch0.size(); k++)
      check($sformatf("slew_up%0d", k), 32'(ch0[k]), 32'(exp_up[k]));
    wr(4'd8, 32'd1000);
    wait_cycles(6);
    stb_q.delete();
    ch0.delete();
    wr(4'd0, 32'h00);
    wr(4'd8, 32'd9);
    wait_cycles(50);
    foreach (stb_q[k]) if (stb_q[k].stb == 4'b0001) ch0.push_back(stb_q[k].dat);
    check("slew_dn_count_ge4", 32'(ch0.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < ch0.size(); k++)
      check($sformatf("slew_dn%0d", k), 32'(ch0[k]), 32'(exp_dn[k]));

    // Overrun: sticky, cleared by read, sets again.
    do_reset();
    wr(4'd8, 32'd2);
    wait_cycles(20);
    wr(4'd8, 32'd1000);
    wait_cycles(6);
    rd(4'd10, d);
    check("overrun_set", d, 32'd1);
    rd(4'd10, d);
    check("overrun_cleared", d, 32'd0);
    wr(4'd8, 32'd2);
    wait_cycles(20);
    wr(4'd8, 32'd1000);
    wait_cycles(6);
    rd(4'd10, d);
    check("overrun_reset_again", d, 32'd1);

    // target[3] written in the cycle its visit is decided.
    do_reset();
    wr(4'd3, 32'h10);
    wr(4'd8, 32'd9);
    stb_q.delete();
    wait_tick(30, seen);
    repeat (3) @(posedge clk);
    #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 4'd3; wb_dat_w = 32'h77;
    @(posedge clk); #1;
    check("race_write_ack", 32'(wb_ack), 32'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wait_cycles(15);
    foreach (stb_q[k]) if (stb_q[k].stb == 4'b1000) ch3.push_back(stb_q[k].dat);
    check("race_count_ge2", 32'(ch3.size() >= 2), 32'd1);
    if (ch3.size() >= 2) begin
      check("race_old_value", 32'(ch3[0]), 32'h10);
      check("race_new_value", 32'(ch3[1]), 32'h77);
    end

    // Reset in the middle of a scan at idx=1.
    do_reset();
    for (int i = 0; i < 4; i++) wr(4'(i), 32'h40);
    wr(4'd8, 32'd9);
    wait_tick(30, seen);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midscan_stb_after_rst", 32'(ch_stb), 32'd0);
    rst = 1'b0;
    fall_cyc = cyc_cnt;
    stb_q.delete();
    wait_tick(1200, seen);
    if (seen) begin
      check("midscan_tick_delay", 32'(cyc_cnt - fall_cyc), 32'd1001);
      check("midscan_no_stb", 32'(stb_q.size()), 32'd0);
    end
    for (int a = 0; a < 11; a++) begin
      rd(4'(a), d);
      check($sformatf("midscan_reg%0d", a), d, (a == 8) ? 32'd1000 : 32'd0);
    end

    check("onehot_violations", 32'(onehot_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
